gx4000_crtc_bridge: RTL and testbench
=====================================

# gx4000_crtc_bridge

Parametrised CPU-to-CRTC register bridge for the GX4000/Plus video path, sitting between the Z80 I/O bus and the motherboard CRTC register port. It decodes &BC–&BF accesses, keeps a shadow copy of the CRTC register file for readback, and queues CPU writes in a FIFO. The queued writes are drained to the motherboard CRTC one access per `crtc_clken` strobe. It replaces the fixed combinational pass-through with buffered, CRTC-type-configurable behaviour and a status register.

## Interface
- `NUM_REGS`, 18: shadow register count (index width is 5 bits; max 32).
- `FIFO_DEPTH`, 4: write queue depth (power of two, ≥2).
- `READ_MASK`, 32'h0003_F000: bit n set means register n is readable via &BF (default regs 12–17).
- `clk_sys` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `plus_mode` in 1: 1 = ASIC CRTC behaviour (&BE mirrors &BF).
- `cpu_addr` in 16: I/O address.
- `cpu_data` in 8: write data.
- `cpu_wr`, `cpu_rd` in 1: level strobes.
- `cpu_dout` out 8: read data, registered.
- `cpu_dout_en` out 1: high when `cpu_dout` carries a CRTC read.
- `crtc_clken` in 1: CRTC clock-enable strobe.
- `crtc_vsync` in 1: CRTC vsync, for status.
- `crtc_enable`, `crtc_cs_n`, `crtc_r_nw`, `crtc_rs` out 1: motherboard CRTC port controls.
- `crtc_data` out 8: motherboard CRTC port data.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current queue occupancy.
- `overflow` out 1: sticky dropped-write flag.

## Operation
- Decode: selected when `cpu_addr[15:10]`=6'b101111. The function is `cpu_addr[9:8]`:
  - 0 = index write.
  - 1 = data write.
  - 2 = status read (or register read when `plus_mode`).
  - 3 = register read.
- Writes act on the rising edge of `cpu_wr` (registered previous value), so a held strobe gives one action. Writes to functions 2 and 3 are ignored.
- Accepted write: push {rs=func[0], data} into the FIFO and update the shadow in the same cycle.
  - Index write: `index` ← `data[4:0]`.
  - Data write: `shadow[index]` ← `data`, only if `index` < `NUM_REGS`.
- Full FIFO with no pop in the same cycle: the write is dropped, `overflow` is set, and the shadow is not updated. Full FIFO with a simultaneous pop: the write is accepted.
- Register read (&BF, or &BE when `plus_mode`=1): `shadow[index]` if `READ_MASK[index]` and `index` < `NUM_REGS`, else 8'h00.
- Status read (&BE, `plus_mode`=0) returns {`overflow`, FIFO non-empty, `crtc_vsync`, `index[4:0]`}. The rising edge of `cpu_rd` on this read clears `overflow`; a set on the same cycle wins.
- Non-selected reads: `cpu_dout`=8'hFF, `cpu_dout_en`=0.
- Drain FSM:
  - IDLE: if the FIFO is non-empty, load the head into `crtc_rs`/`crtc_data`, drive `crtc_cs_n`=0 and `crtc_r_nw`=0, then go to DRIVE.
  - DRIVE: on a cycle with `crtc_clken`=1, assert `crtc_enable` for exactly that cycle, pop, and return to IDLE with `crtc_cs_n`=1 and `crtc_r_nw`=1 next cycle.
- The motherboard sees writes in exact CPU order. Index/data pairing is preserved by the FIFO.

## Timing
- Reset values:
  - `cpu_dout`=8'hFF, `cpu_dout_en`=0.
  - `crtc_enable`=0, `crtc_cs_n`=1, `crtc_r_nw`=1, `crtc_rs`=0, `crtc_data`=8'h00.
  - `fifo_level`=0, `overflow`=0.
  - `index`=0, all shadow registers 0, FSM in IDLE.
- A reset asserted in DRIVE aborts the access immediately and no `crtc_enable` is issued.
- Read latency: `cpu_dout` is valid 1 cycle after a cycle with `cpu_rd`=1 and a selected address, and is held while `cpu_rd` stays high.
- The shadow is visible to a read one cycle after the write edge.
- Write-to-CRTC latency: the first `crtc_clken` at least 2 cycles after the write edge (push → IDLE load → DRIVE).
- Sustained throughput: one entry per `crtc_clken` if strobes are ≥2 cycles apart.
- `fifo_level` updates the cycle after a push or pop. A simultaneous push and pop leaves it unchanged.

## Structure
- Package `gx4000_crtc_pkg` holds:
  - Function-code constants `CRTC_FN_INDEX`/`DATA`/`STATUS`/`READ`.
  - The drain FSM state enum {IDLE, DRIVE}.
  - The FIFO entry width constant (9).
- Sub-module `gx4000_sync_fifo`: parametrised depth/width synchronous FIFO with `full`, `empty`, `level`, and a same-cycle push/pop-when-full rule.
- The shadow file, decode, status logic and FSM live in the top module.

## Test plan
- Index write 8'h0C, data write 8'h30, with `crtc_clken` every 4 cycles: two CRTC accesses (rs=0 data 0C, then rs=1 data 30), each with a single-cycle `crtc_enable`. A subsequent &BF read returns 8'h30.
- Index 8'h01, data 8'h28, &BF read: returns 8'h00 (not in `READ_MASK`). The CRTC still receives the write.
- `crtc_clken` held low, 5 write edges with `FIFO_DEPTH`=4: `fifo_level`=4, `overflow`=1, 5th write absent from the shadow. A &BE read returns bit7=1, and a second read returns bit7=0.
- Hold `cpu_wr` high for 10 cycles on &BD: exactly one FIFO push.
- `plus_mode`=1, index 12, data 8'h3F, &BE read: returns 8'h3F.
- Assert `reset` while in DRIVE: no `crtc_enable` pulse, `crtc_cs_n`=1, `fifo_level`=0, &BF read of reg 12 returns 8'h00.

Source files
------------

// File: rtl/gx4000_crtc_pkg.sv
// gx4000_crtc_pkg: shared constants and types for the GX4000 CRTC bridge
package gx4000_crtc_pkg;
  localparam logic [1:0] CRTC_FN_INDEX  = 2'd0;
  localparam logic [1:0] CRTC_FN_DATA   = 2'd1;
  localparam logic [1:0] CRTC_FN_STATUS = 2'd2;
  localparam logic [1:0] CRTC_FN_READ   = 2'd3;
  localparam int CRTC_ENTRY_W = 9;
  typedef enum logic {IDLE, DRIVE} drain_state_e;
endpackage

// File: rtl/gx4000_sync_fifo.sv
// gx4000_sync_fifo: synchronous FIFO; a push into a full FIFO is taken only when a pop happens in the same cycle
// Ports: clk/rst (async active-high), push/din, pop/dout (head, valid while !empty), full, empty, level
module gx4000_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    full = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
    do_pop = pop & ~empty;
    do_push = push & (~full | do_pop);
    wp_d = do_push ? wp_q + 1'b1 : wp_q;
    rp_d = do_pop ? rp_q + 1'b1 : rp_q;
    cnt_d = (do_push & ~do_pop) ? cnt_q + 1'b1 : (do_pop & ~do_push) ? cnt_q - 1'b1 : cnt_q;
  end
  assign dout = mem_q[rp_q];
  assign level = cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q] <= din;
endmodule

// File: rtl/gx4000_crtc_bridge.sv
// gx4000_crtc_bridge: Z80 &BC-&BF decode, CRTC shadow/readback, status register and buffered drain to the motherboard CRTC
// Ports: clk_sys/reset (async active-high); cpu_* bus side (level strobes, registered cpu_dout);
//        crtc_clken/crtc_vsync in, crtc_enable/cs_n/r_nw/rs/data out; fifo_level, sticky overflow
module gx4000_crtc_bridge
  import gx4000_crtc_pkg::*;
#(
  parameter int NUM_REGS = 18,
  parameter int FIFO_DEPTH = 4,
  parameter logic [31:0] READ_MASK = 32'h0003_F000,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          plus_mode,
  input  logic [15:0]   cpu_addr,
  input  logic [7:0]    cpu_data,
  input  logic          cpu_wr,
  input  logic          cpu_rd,
  output logic [7:0]    cpu_dout,
  output logic          cpu_dout_en,
  input  logic          crtc_clken,
  input  logic          crtc_vsync,
  output logic          crtc_enable,
  output logic          crtc_cs_n,
  output logic          crtc_r_nw,
  output logic          crtc_rs,
  output logic [7:0]    crtc_data,
  output logic [LW-1:0] fifo_level,
  output logic          overflow
);
  localparam logic [5:0] NR = 6'(NUM_REGS);
  logic wr_q, rd_q, overflow_q, overflow_d, dout_en_q, dout_en_d, rs_q, rs_d;
  logic [4:0] index_q, index_d;
  logic [7:0] dout_q, dout_d, data_q, data_d, reg_val;
  logic [7:0] shadow_q [NUM_REGS];
  logic [7:0] shadow_d [NUM_REGS];
  drain_state_e state_q, state_d;
  logic sel, wr_edge, pop, accept, idx_ok, rd_reg, rd_stat, full, empty;
  logic [1:0] fn;
  logic [CRTC_ENTRY_W-1:0] head;
  logic unused_addr;
  assign unused_addr = &{1'b0, cpu_addr[7:0]};
  gx4000_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CRTC_ENTRY_W)) u_fifo (
    .clk(clk_sys), .rst(reset), .push(wr_edge), .pop(pop), .din({fn[0], cpu_data}),
    .dout(head), .full(full), .empty(empty), .level(fifo_level)
  );
  always_comb begin
    sel = cpu_addr[15:10] == 6'b101111;
    fn = cpu_addr[9:8];
    wr_edge = sel & cpu_wr & ~wr_q & ~fn[1];
    pop = (state_q == DRIVE) & crtc_clken;
    // a full FIFO still accepts when the drain pops in the same cycle
    accept = wr_edge & (~full | pop);
    idx_ok = {1'b0, index_q} < NR;
    rd_reg = sel & ((fn == CRTC_FN_READ) | ((fn == CRTC_FN_STATUS) & plus_mode));
    rd_stat = sel & (fn == CRTC_FN_STATUS) & ~plus_mode;
    reg_val = (READ_MASK[index_q] & idx_ok) ? shadow_q[index_q] : 8'h00;
    index_d = (accept & (fn == CRTC_FN_INDEX)) ? cpu_data[4:0] : index_q;
    shadow_d = shadow_q;
    if (accept & (fn == CRTC_FN_DATA) & idx_ok) shadow_d[index_q] = cpu_data;
    // a drop on the same cycle as the clearing status read keeps the flag set
    overflow_d = (wr_edge & full & ~pop) | (overflow_q & ~(rd_stat & cpu_rd & ~rd_q));
    dout_d = (cpu_rd & rd_reg) ? reg_val
           : (cpu_rd & rd_stat) ? {overflow_q, ~empty, crtc_vsync, index_q} : 8'hFF;
    dout_en_d = cpu_rd & (rd_reg | rd_stat);
    state_d = (state_q == IDLE) ? (empty ? IDLE : DRIVE) : (crtc_clken ? IDLE : DRIVE);
    rs_d = (state_q == IDLE & ~empty) ? head[8] : rs_q;
    data_d = (state_q == IDLE & ~empty) ? head[7:0] : data_q;
  end
  // strobes derive from state so an async reset in DRIVE kills the access at once
  assign crtc_enable = (state_q == DRIVE) & crtc_clken;
  assign crtc_cs_n = state_q != DRIVE;
  assign crtc_r_nw = state_q != DRIVE;
  assign crtc_rs = rs_q;
  assign crtc_data = data_q;
  assign cpu_dout = dout_q;
  assign cpu_dout_en = dout_en_q;
  assign overflow = overflow_q;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      overflow_q <= 1'b0;
      dout_q <= 8'hFF;
      dout_en_q <= 1'b0;
      rs_q <= 1'b0;
      data_q <= 8'h00;
      index_q <= '0;
      shadow_q <= '{default: 8'h00};
      state_q <= IDLE;
    end else begin
      wr_q <= cpu_wr;
      rd_q <= cpu_rd;
      overflow_q <= overflow_d;
      dout_q <= dout_d;
      dout_en_q <= dout_en_d;
      rs_q <= rs_d;
      data_q <= data_d;
      index_q <= index_d;
      shadow_q <= shadow_d;
      state_q <= state_d;
    end
endmodule

// File: tb/tb_gx4000_crtc_bridge.sv
// tb_gx4000_crtc_bridge: directed and randomized checks of the bridge against a queue/array reference model
module tb_gx4000_crtc_bridge;
  logic clk_sys = 0, reset = 1, plus_mode = 0, cpu_wr = 0, cpu_rd = 0, crtc_clken = 0, crtc_vsync = 0;
  logic [15:0] cpu_addr = 0;
  logic [7:0] cpu_data = 0, cpu_dout, crtc_data;
  logic cpu_dout_en, crtc_enable, crtc_cs_n, crtc_r_nw, crtc_rs, overflow;
  logic [2:0] fifo_level;
  int total = 0, bad = 0, ken_period = 0, cyc = 0, enables = 0, idx = 0;
  logic [8:0] exp_q [$];
  logic [7:0] sh [18];
  logic [31:0] rmask = 32'h0003_F000;
  bit ovf = 0, prev_en = 0;

  gx4000_crtc_bridge dut (
    .clk_sys(clk_sys), .reset(reset), .plus_mode(plus_mode), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_dout(cpu_dout), .cpu_dout_en(cpu_dout_en),
    .crtc_clken(crtc_clken), .crtc_vsync(crtc_vsync), .crtc_enable(crtc_enable), .crtc_cs_n(crtc_cs_n),
    .crtc_r_nw(crtc_r_nw), .crtc_rs(crtc_rs), .crtc_data(crtc_data), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk_sys);
    #1;
    cyc++;
    crtc_clken = (ken_period != 0) && (cyc % ken_period == 0);
  end

  always @(negedge clk_sys) begin
    if (crtc_enable) begin
      enables++;
      chk("en_single_cycle", 32'(prev_en), 0);
      chk("en_has_pending", 32'(exp_q.size() > 0), 1);
      chk("crtc_cs_rnw", {crtc_cs_n, crtc_r_nw}, 0);
      if (exp_q.size() > 0) begin
        chk("crtc_word", {crtc_rs, crtc_data}, exp_q[0]);
        exp_q.delete(0);
      end
    end
    prev_en = crtc_enable;
  end

  function automatic logic [7:0] model_reg();
    return (idx < 18 && rmask[idx]) ? sh[idx] : 8'h00;
  endfunction

  task automatic wr(input logic [1:0] fn, input logic [7:0] d);
    cpu_addr = {6'b101111, fn, 8'($urandom)};
    cpu_data = d;
    cpu_wr = 1;
    @(posedge clk_sys);
    #1 cpu_wr = 0;
    if (fn < 2) begin
      if (exp_q.size() < 4) begin
        exp_q.push_back({fn[0], d});
        if (fn == 0) idx = int'(d[4:0]);
        else if (idx < 18) sh[idx] = d;
      end else ovf = 1;
    end
    @(posedge clk_sys);
    #1;
  endtask

  task automatic rchk(input string tag, input logic [1:0] fn);
    logic [7:0] e;
    e = (fn == 3 || (fn == 2 && plus_mode)) ? model_reg()
      : {ovf, exp_q.size() != 0, crtc_vsync, 5'(idx)};
    cpu_addr = {6'b101111, fn, 8'($urandom)};
    cpu_rd = 1;
    @(posedge clk_sys);
    #1;
    chk(tag, cpu_dout, e);
    chk({tag, "_en"}, cpu_dout_en, 1);
    cpu_rd = 0;
    if (fn == 2 && !plus_mode) ovf = 0;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic drain(input int per);
    ken_period = per;
    for (int t = 0; t < 400 && exp_q.size() != 0; t++) @(posedge clk_sys);
    repeat (3) @(posedge clk_sys);
    #1;
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_level", fifo_level, 0);
    ken_period = 0;
    @(posedge clk_sys);
    #1;
  endtask

  initial begin : main
    int n, e0;
    logic [1:0] f;
    logic [7:0] d;
    foreach (sh[i]) sh[i] = 0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_dout", cpu_dout, 8'hFF);
    chk("rst_dout_en", cpu_dout_en, 0);
    chk("rst_enable", crtc_enable, 0);
    chk("rst_cs_n", crtc_cs_n, 1);
    chk("rst_r_nw", crtc_r_nw, 1);
    chk("rst_rs", crtc_rs, 0);
    chk("rst_data", crtc_data, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);
    reset = 0;
    @(posedge clk_sys);
    #1;
    rchk("rst_status", 2);
    // index 12 / data 30 drained with a strobe every 4 cycles
    e0 = enables;
    wr(0, 8'h0C);
    wr(1, 8'h30);
    drain(4);
    chk("t1_accesses", enables - e0, 2);
    rchk("t1_bf", 3);
    // register 1 is write-only for readback
    e0 = enables;
    wr(0, 8'h01);
    wr(1, 8'h28);
    drain(3);
    chk("t2_accesses", enables - e0, 2);
    rchk("t2_bf", 3);
    // overflow with the drain stalled
    wr(0, 8'h0C);
    wr(1, 8'hAA);
    wr(0, 8'h0D);
    wr(1, 8'hBB);
    wr(1, 8'hCC);
    chk("t3_level", fifo_level, 4);
    chk("t3_overflow", overflow, 1);
    crtc_vsync = 1;
    rchk("t3_stat1", 2);
    rchk("t3_stat2", 2);
    chk("t3_overflow_clr", overflow, 0);
    rchk("t3_bf13", 3);
    drain(3);
    // held write strobe gives one push
    cpu_addr = 16'hBD00;
    cpu_data = 8'h5A;
    cpu_wr = 1;
    repeat (10) @(posedge clk_sys);
    #1 cpu_wr = 0;
    exp_q.push_back({1'b1, 8'h5A});
    sh[idx] = 8'h5A;
    @(posedge clk_sys);
    #1;
    chk("t4_level", fifo_level, 1);
    drain(4);
    rchk("t4_bf", 3);
    // plus mode mirrors &BF on &BE
    plus_mode = 1;
    wr(0, 8'h0C);
    wr(1, 8'h3F);
    rchk("t5_plus_be", 2);
    plus_mode = 0;
    drain(2);
    // randomized bursts that never exceed the queue depth
    for (int it = 0; it < 20; it++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        f = 2'($urandom_range(0, 1));
        d = 8'($urandom);
        if (f == 0 && $urandom_range(0, 2) != 0) d = 8'($urandom_range(10, 19));
        wr(f, d);
      end
      chk("rnd_level", fifo_level, exp_q.size());
      plus_mode = 1'($urandom_range(0, 1));
      crtc_vsync = 1'($urandom_range(0, 1));
      rchk("rnd_be", 2);
      drain($urandom_range(2, 5));
      rchk("rnd_bf", 3);
    end
    plus_mode = 0;
    // reset while an access is being driven
    wr(0, 8'h0C);
    wr(1, 8'h55);
    chk("t6_in_drive", crtc_cs_n, 0);
    reset = 1;
    exp_q.delete();
    foreach (sh[i]) sh[i] = 0;
    idx = 0;
    ovf = 0;
    ken_period = 1;
    crtc_clken = 1;
    #1;
    chk("t6_enable", crtc_enable, 0);
    chk("t6_cs_n", crtc_cs_n, 1);
    repeat (3) @(posedge clk_sys);
    #1;
    chk("t6_level", fifo_level, 0);
    chk("t6_overflow", overflow, 0);
    reset = 0;
    ken_period = 0;
    @(posedge clk_sys);
    #1;
    wr(0, 8'h0C);
    rchk("t6_bf12", 3);
    drain(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
